bin_to_bcd_seq: RTL and testbench

// - Iterative (double-dabble) binary-to-BCD converter feeding the 4-digit 7-segment scan driver.
// - Takes the running count, returns DIGITS packed BCD nibbles; start/done/busy handshake.
// - bcd_out is registered and changes only on completion, so the display never scans partial digits.
// - One shift per clock: area is small, latency is BIN_W+1 cycles.

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/bcd_add3.sv | 15 +
 rtl/bin_to_bcd_seq.sv | 129 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Brief    : Shared types, constants and helpers for the binary-to-BCD converter
//  Revision : 1.0
// ============================================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam int         NIBBLE_W = 4;
    localparam logic [3:0] BCD_NINE = 4'h9;

    // 10**n, used to build the overflow threshold at elaboration time
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_add3
//  Brief    : Double-dabble digit correction, adds 3 to any nibble >= 5
//  Revision : 1.0
// ============================================================================
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule : bcd_add3
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_seq
//  Brief    : Iterative double-dabble binary-to-BCD converter, one shift/clock
//  Revision : 1.0
// ============================================================================
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET_N,
    input  logic                         start,
    input  logic [BIN_W-1:0]             bin_in,
    output logic                         busy,
    output logic                         done,
    output logic                         ovf,
    output logic [NIBBLE_W*DIGITS-1:0]   bcd_out
);

    localparam int               CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int               WORK_W   = NIBBLE_W * (DIGITS + 1);
    localparam int               OUT_W    = NIBBLE_W * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [31:0]      OVF_LIM  = 32'(pow10(DIGITS));

    bcd_state_t         state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [WORK_W-1:0]  work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_cap_q, ovf_cap_d;
    logic               ovf_q, ovf_d;
    logic [OUT_W-1:0]   bcd_q, bcd_d;

    logic [WORK_W-1:0]  w_work_adj;
    logic [WORK_W-1:0]  w_work_shl;
    logic               w_capture;
    logic               w_last;
    logic               w_ovf_in;
    logic               w_unused;

    // Spare top nibble keeps inputs above 10**DIGITS from corrupting the shift
    generate
        for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
            bcd_add3 u_add3 (
                .digit_i (work_q[g*NIBBLE_W +: NIBBLE_W]),
                .digit_o (w_work_adj[g*NIBBLE_W +: NIBBLE_W])
            );
        end
    endgenerate

    assign w_work_shl = {w_work_adj[WORK_W-2:0], shift_q[BIN_W-1]};
    assign w_unused   = w_work_adj[WORK_W-1];
    assign w_capture  = start && ((state_q == IDLE) || (state_q == DONE));
    assign w_last     = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign w_ovf_in   = (32'(bin_in) >= OVF_LIM);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        ovf_cap_d = ovf_cap_q;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        if (w_capture) begin
            shift_d   = bin_in;
            work_d    = '0;
            cnt_d     = '0;
            ovf_cap_d = w_ovf_in;
        end else if (state_q == SHIFT) begin
            work_d  = w_work_shl;
            shift_d = shift_q << 1;
            if (w_last) begin
                // Results publish on the same edge that enters DONE
                bcd_d = ovf_cap_q ? {DIGITS{BCD_NINE}} : w_work_shl[OUT_W-1:0];
                ovf_d = ovf_cap_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            shift_q   <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            ovf_cap_q <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
        end else begin
            shift_q   <= shift_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            ovf_cap_q <= ovf_cap_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
        end
    end

    always_comb begin
        busy    = (state_q == SHIFT);
        done    = (state_q == DONE);
        ovf     = ovf_q;
        bcd_out = bcd_q;
    end

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_bcd_seq
//  Brief    : Directed self-checking bench for bin_to_bcd_seq
//  Revision : 1.0
// ============================================================================
module tb_bin_to_bcd_seq;

    logic        CLOCK_50;
    logic        RESET_N;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] bcd_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .bcd_out  (bcd_out)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bcd_ref(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Polls at negedges until done, counting busy cycles on the way
    task automatic wait_done(output int busy_cycles, output logic got);
        busy_cycles = 0;
        got         = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge CLOCK_50);
        end
    endtask

    task automatic do_conv(input string tag, input logic [13:0] v,
                           input logic [15:0] exp_bcd, input logic exp_ovf);
        int   bc;
        logic got;
        @(negedge CLOCK_50);
        bin_in = v;
        start  = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        wait_done(bc, got);
        check_eq({tag, "_done"}, 32'(got), 32'd1);
        check_eq({tag, "_busy"}, 32'(bc), 32'd14);
        check_eq({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        @(negedge CLOCK_50);
        check_eq({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int   bc, t1, t2, rv;
        logic got, seen;

        RESET_N = 1'b0;
        start   = 1'b0;
        bin_in  = '0;
        repeat (3) @(negedge CLOCK_50);
        check_eq("rst_bcd", 32'(bcd_out), 32'h0);
        check_eq("rst_flags", {29'd0, busy, done, ovf}, 32'h0);
        RESET_N = 1'b1;

        seen = 1'b0;
        repeat (20) begin
            @(negedge CLOCK_50);
            if (busy || done || ovf) seen = 1'b1;
        end
        check_eq("idle_quiet", 32'(seen), 32'd0);
        check_eq("idle_bcd", 32'(bcd_out), 32'h0);

        do_conv("c1234", 14'd1234, 16'h1234, 1'b0);

        // Back-to-back: start held through DONE captures the second value
        @(negedge CLOCK_50);
        bin_in = 14'd9999;
        start  = 1'b1;
        @(negedge CLOCK_50);
        bin_in = 14'd0;
        wait_done(bc, got);
        t1 = cyc;
        check_eq("b2b1_done", 32'(got), 32'd1);
        check_eq("b2b1_bcd", 32'(bcd_out), 32'h9999);
        @(negedge CLOCK_50);
        start = 1'b0;
        check_eq("b2b_rebusy", 32'(busy), 32'd1);
        wait_done(bc, got);
        t2 = cyc;
        check_eq("b2b2_done", 32'(got), 32'd1);
        check_eq("b2b2_bcd", 32'(bcd_out), 32'h0000);
        check_eq("b2b_gap", 32'(t2 - t1), 32'd15);

        do_conv("c10000", 14'd10000, 16'h9999, 1'b1);
        do_conv("c16383", 14'd16383, 16'h9999, 1'b1);
        do_conv("c42", 14'd42, 16'h0042, 1'b0);

        // Starts while busy must be ignored
        @(negedge CLOCK_50);
        bin_in = 14'd3456;
        start  = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (3) begin
            @(negedge CLOCK_50);
            bin_in = 14'd1111;
            start  = 1'b1;
            @(negedge CLOCK_50);
            start  = 1'b0;
            bin_in = 14'd7777;
        end
        wait_done(bc, got);
        check_eq("ign_done", 32'(got), 32'd1);
        check_eq("ign_bcd", 32'(bcd_out), 32'h3456);
        @(negedge CLOCK_50);
        check_eq("ign_idle", 32'(busy), 32'd0);

        // Reset in the middle of a conversion
        bin_in = 14'd5678;
        start  = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        RESET_N = 1'b0;
        #1;
        check_eq("abort_bcd", 32'(bcd_out), 32'h0);
        check_eq("abort_flags", {29'd0, busy, done, ovf}, 32'h0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge CLOCK_50);
            if (done || busy) seen = 1'b1;
        end
        RESET_N = 1'b1;
        repeat (20) begin
            @(negedge CLOCK_50);
            if (done || busy) seen = 1'b1;
        end
        check_eq("abort_nodone", 32'(seen), 32'd0);
        do_conv("c5678", 14'd5678, 16'h5678, 1'b0);

        do_conv("c9", 14'd9, 16'h0009, 1'b0);
        do_conv("c1000", 14'd1000, 16'h1000, 1'b0);
        for (int k = 0; k < 12; k++) begin
            rv = int'($urandom_range(0, 9999));
            do_conv("rnd", 14'(rv), bcd_ref(rv), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire
